// File: rtl/spi_master_tx.sv
// spi_master_tx: mode-0 SPI transmit master, 32-bit words, standard or quad output lanes.
module spi_master_tx (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        clr,
  input  logic [7:0]  clk_div,
  input  logic        clk_div_valid,
  input  logic        en,
  input  logic [15:0] tx_len,
  input  logic        quad,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        busy,
  output logic        tx_done,
  output logic        spi_clk,
  output logic        spi_sdo0,
  output logic        spi_sdo1,
  output logic        spi_sdo2,
  output logic        spi_sdo3
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state, state_nxt;
  logic [7:0]  div_reg, div_cnt;
  logic [15:0] bit_cnt, step, bit_nxt;
  logic [5:0]  word_cnt, word_nxt;
  logic [31:0] shift_reg;
  logic        quad_r, tick, fall;
  assign tick     = state == SHIFT && div_cnt >= div_reg;
  assign fall     = tick && spi_clk;
  assign step     = quad_r ? 16'd4 : 16'd1;
  assign bit_nxt  = bit_cnt > step ? bit_cnt - step : 16'd0;
  assign word_nxt = word_cnt - 6'd1;
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = clr ? IDLE :
                state == IDLE ? ((en && tx_len != 16'd0) ? LOAD : IDLE) :
                state == LOAD ? (tx_valid ? SHIFT : LOAD) :
                (fall && bit_nxt == 16'd0) ? IDLE :
                (fall && word_nxt == 6'd0) ? LOAD : SHIFT;
  end
  always_comb begin
    tx_ready = state == LOAD;
    busy     = state != IDLE;
    {spi_sdo3, spi_sdo2, spi_sdo1, spi_sdo0} = state != SHIFT ? 4'b0 :
                                               quad_r ? shift_reg[31:28] : {3'b0, shift_reg[31]};
  end
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      div_reg   <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      shift_reg <= '0;
      quad_r    <= 1'b0;
      spi_clk   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      if (clk_div_valid) div_reg <= clk_div;
      tx_done <= 1'b0;
      if (clr) begin
        div_cnt   <= '0;
        bit_cnt   <= '0;
        word_cnt  <= '0;
        shift_reg <= '0;
        spi_clk   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            div_cnt <= '0;
            spi_clk <= 1'b0;
            if (en && tx_len == 16'd0) tx_done <= 1'b1;
            if (en && tx_len != 16'd0) begin
              bit_cnt <= tx_len;
              quad_r  <= quad;
            end
          end
          LOAD: begin
            div_cnt <= '0;
            spi_clk <= 1'b0;
            if (tx_valid) begin
              shift_reg <= tx_data;
              word_cnt  <= quad_r ? 6'd8 : 6'd32;
            end
          end
          SHIFT: begin
            div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
            if (tick) spi_clk <= ~spi_clk;
            // data only moves on the falling edge; the slave samples on the rising one
            if (fall) begin
              bit_cnt  <= bit_nxt;
              word_cnt <= word_nxt;
              if (bit_nxt == 16'd0) tx_done <= 1'b1;
              else if (word_nxt != 6'd0) shift_reg <= quad_r ? shift_reg << 4 : shift_reg << 1;
            end
          end
          default: spi_clk <= 1'b0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_master_tx.sv
// tb_spi_master_tx: scoreboard bench; expected sdo values queued at start, popped on each spi_clk rise.
module tb_spi_master_tx;
  logic        HCLK = 0, HRESET = 1, clr = 0, clk_div_valid = 0, en = 0, quad = 0, tx_valid = 0;
  logic [7:0]  clk_div = 0;
  logic [15:0] tx_len = 0;
  logic [31:0] tx_data = 0;
  logic        tx_ready, busy, tx_done, spi_clk, spi_sdo0, spi_sdo1, spi_sdo2, spi_sdo3;
  logic [3:0]  sdo;
  logic [3:0]  exp_q[$];
  int          n_cmp = 0, n_err = 0, rises = 0, dones = 0, hs = 0, hi_cnt = 0, exp_half = 1;
  bit          chk_half = 0;
  logic        clk_prev = 0;
  assign sdo = {spi_sdo3, spi_sdo2, spi_sdo1, spi_sdo0};

  spi_master_tx dut (
    .HCLK(HCLK), .HRESET(HRESET), .clr(clr), .clk_div(clk_div), .clk_div_valid(clk_div_valid),
    .en(en), .tx_len(tx_len), .quad(quad), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .tx_done(tx_done), .spi_clk(spi_clk),
    .spi_sdo0(spi_sdo0), .spi_sdo1(spi_sdo1), .spi_sdo2(spi_sdo2), .spi_sdo3(spi_sdo3)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge HCLK) begin
    if (HRESET) begin
      clk_prev = 0;
      hi_cnt = 0;
    end else begin
      if (spi_clk && !clk_prev) begin
        rises++;
        hi_cnt = 1;
        if (exp_q.size() == 0) check("extra_clk", 32'd1, 32'd0);
        else check("sdo", {28'b0, sdo}, {28'b0, exp_q.pop_front()});
      end else if (spi_clk) hi_cnt++;
      else if (clk_prev && chk_half) check("half_period", hi_cnt, exp_half);
      if (tx_done) begin
        dones++;
        check("done_not_busy", {31'b0, busy}, 32'd0);
      end
      if (tx_valid && tx_ready) hs++;
      clk_prev = spi_clk;
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #2;
  endtask

  task automatic set_div(logic [7:0] d);
    clk_div = d;
    clk_div_valid = 1;
    tick();
    clk_div_valid = 0;
    exp_half = int'(d) + 1;
  endtask

  task automatic start(int len, bit qd, logic [31:0] w0, logic [31:0] w1);
    int clocks, cap;
    logic [31:0] w;
    clocks = qd ? (len + 3) / 4 : len;
    cap = qd ? 8 : 32;
    for (int i = 0; i < clocks; i++) begin
      w = (i / cap) != 0 ? w1 : w0;
      exp_q.push_back(qd ? w[31 - 4 * (i % cap) -: 4] : {3'b0, w[31 - (i % cap)]});
    end
    tx_len = 16'(len);
    quad = qd;
    en = 1;
    tick();
    en = 0;
  endtask

  task automatic feed(logic [31:0] w, int stall);
    int k = 0;
    while (!tx_ready && k < 200) begin
      tick();
      k++;
    end
    if (!tx_ready) check("ready_wait", {31'b0, tx_ready}, 32'd1);
    for (int s = 0; s < stall; s++) begin
      check("stall_clk", {31'b0, spi_clk}, 32'd0);
      check("stall_ready", {31'b0, tx_ready}, 32'd1);
      tick();
    end
    tx_data = w;
    tx_valid = 1;
    tick();
    tx_valid = 0;
  endtask

  task automatic wait_rises(int n);
    int k = 0;
    while (rises < n && k < 2000) begin
      tick();
      k++;
    end
    if (rises < n) check("rise_wait", rises, n);
  endtask

  task automatic finish_xfer(int d0, int h0, int nw);
    int k = 0;
    while (dones < d0 + 1 && k < 4000) begin
      tick();
      k++;
    end
    if (dones < d0 + 1) check("done_wait", dones, d0 + 1);
    tick();
    check("done_count", dones, d0 + 1);
    check("queue_empty", exp_q.size(), 0);
    check("handshakes", hs - h0, nw);
    check("idle_busy", {31'b0, busy}, 32'd0);
  endtask

  task automatic check_quiet(string tag);
    check({tag, "_clk"}, {31'b0, spi_clk}, 32'd0);
    check({tag, "_sdo"}, {28'b0, sdo}, 32'd0);
    check({tag, "_ready"}, {31'b0, tx_ready}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, tx_done}, 32'd0);
  endtask

  initial begin
    int d0, h0, r0;
    tick();
    tick();
    check_quiet("reset");
    HRESET = 0;
    tick();
    check_quiet("post_reset");

    set_div(1);
    chk_half = 1;
    d0 = dones; h0 = hs; r0 = rises;
    start(8, 0, 32'hA5000000, 32'h0);
    feed(32'hA5000000, 0);
    finish_xfer(d0, h0, 1);
    check("rises_std8", rises - r0, 8);

    set_div(0);
    d0 = dones; h0 = hs; r0 = rises;
    start(40, 1, 32'h12345678, 32'h9A000000);
    feed(32'h12345678, 0);
    feed(32'h9A000000, 5);
    finish_xfer(d0, h0, 2);
    check("rises_quad40", rises - r0, 10);

    set_div(1);
    d0 = dones; h0 = hs; r0 = rises;
    start(6, 1, 32'hF3000000, 32'h0);
    feed(32'hF3000000, 0);
    finish_xfer(d0, h0, 1);
    check("rises_quad6", rises - r0, 2);

    d0 = dones; h0 = hs;
    tx_len = 0;
    en = 1;
    tick();
    en = 0;
    check("len0_done", {31'b0, tx_done}, 32'd1);
    check("len0_busy", {31'b0, busy}, 32'd0);
    check("len0_ready", {31'b0, tx_ready}, 32'd0);
    tick();
    check("len0_pulse", {31'b0, tx_done}, 32'd0);
    check("len0_count", dones, d0 + 1);
    check("len0_hs", hs, h0);

    d0 = dones; h0 = hs; r0 = rises;
    start(16, 0, 32'hC3A50000, 32'h0);
    feed(32'hC3A50000, 0);
    repeat (6) tick();
    tx_len = 4;
    en = 1;
    tick();
    en = 0;
    finish_xfer(d0, h0, 1);
    check("rises_en_mid", rises - r0, 16);

    chk_half = 0;
    d0 = dones; r0 = rises;
    start(32, 0, 32'h80000001, 32'h0);
    feed(32'h80000001, 0);
    wait_rises(r0 + 3);
    clr = 1;
    tick();
    clr = 0;
    check_quiet("clr");
    repeat (4) tick();
    check("clr_no_done", dones, d0);
    exp_q.delete();
    chk_half = 1;
    d0 = dones; h0 = hs; r0 = rises;
    start(6, 1, 32'hF3000000, 32'h0);
    feed(32'hF3000000, 0);
    finish_xfer(d0, h0, 1);
    check("rises_after_clr", rises - r0, 2);

    chk_half = 0;
    d0 = dones; r0 = rises;
    start(32, 0, 32'hFFFF0000, 32'h0);
    feed(32'hFFFF0000, 0);
    wait_rises(r0 + 3);
    #1 HRESET = 1;
    #1 check_quiet("hreset");
    tick();
    HRESET = 0;
    repeat (3) tick();
    check("hreset_no_done", dones, d0);
    exp_q.delete();

    set_div(0);
    chk_half = 1;
    d0 = dones; h0 = hs; r0 = rises;
    start(32, 0, 32'hDEADBEEF, 32'h0);
    feed(32'hDEADBEEF, 0);
    wait_rises(r0 + 4);
    chk_half = 0;
    clk_div = 3;
    clk_div_valid = 1;
    tick();
    clk_div_valid = 0;
    wait_rises(r0 + 6);
    exp_half = 4;
    chk_half = 1;
    finish_xfer(d0, h0, 1);
    check("rises_div_change", rises - r0, 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
